oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite DMA engine for CPU register $4014; sits directly upstream of the CPU-side memory mapper (WRAM) and drives its addr/WE/oam_dma inputs while active.
- A CPU write of page P to $4014 stalls the CPU.
- The engine then copies 256 bytes from $PP00-$PPFF to OAMDATA ($2004), one read/write pair per byte.
- Releases the CPU when the copy is done.

Parameters:
- TRIG_ADDR, 16'h4014, CPU address that starts a DMA.
- OAMDATA_ADDR, 16'h2004, PPU OAM data port targeted by each DMA write.

Ports:
- clk  in  1  system clock; one clk = one CPU cycle.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU bus address.
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data; page number on trigger.
- mem_rdata  in  8  read data from WRAM (data_out); valid the cycle after address presented.
- dma_addr  out  16  address to mapper while oam_dma=1.
- dma_we  out  1  write strobe to mapper while oam_dma=1.
- dma_wdata  out  8  write data to mapper.
- oam_dma  out  1  high while engine owns the bus; mapper muxes dma_* over CPU signals.
- cpu_rdy  out  1  low = CPU stalled.
- done  out  1  one-cycle pulse after final write.

Behaviour:
- Reset values: dma_addr=16'h0000, dma_we=0, dma_wdata=0, oam_dma=0, cpu_rdy=1, done=0, page=0, idx=0, state=IDLE, parity=0.
- parity: a 1-bit flop that toggles every clk. Reset clears it to 0.
- Trigger is cpu_we && cpu_addr==TRIG_ADDR while in IDLE.
  - On trigger, latch page=cpu_wdata and idx=0, then go to ALIGN.
  - Triggers outside IDLE are ignored (no restart, no page change).
- States: IDLE, ALIGN, ALIGN2, READ, WRITE, DONE.
- IDLE:
  - oam_dma=0, cpu_rdy=1.
  - Goes to ALIGN on trigger.
- ALIGN:
  - Dummy cycle; oam_dma=1, cpu_rdy=0, dma_we=0.
  - Goes to ALIGN2 if parity==1 (OAM_DMA_ODD_ALIGN_EN only), otherwise to READ.
- ALIGN2:
  - Dummy cycle, same outputs as ALIGN.
  - Goes to READ.
- READ:
  - dma_addr={page,idx}, dma_we=0.
  - Goes to WRITE.
- WRITE:
  - dma_addr=OAMDATA_ADDR, dma_we=1, dma_wdata=mem_rdata (combinational pass-through).
  - If idx==8'hFF go to DONE, else idx+1 and go to READ.
  - idx is 8 bits; the wrap from FF to 00 is the termination point.
- DONE:
  - oam_dma=0, dma_we=0, cpu_rdy=1, done=1 for this single cycle.
  - Goes to IDLE.
  - A trigger seen in DONE is ignored.
- Outputs are decoded from registered state (Moore), except dma_wdata.
- dma_addr holds its last value in IDLE/DONE.
- Latency: trigger at cycle T; cpu_rdy is low from T+1 through T+513 (even parity) or T+514 (odd); done pulses the next cycle.
- Stall length is exactly 513 or 514 cycles.
- Exactly 256 writes to OAMDATA_ADDR per DMA, in ascending source order.
- Page FF reads $FF00-$FFFF with no wrap into page 00.
- Reset asserted mid-DMA: next edge returns to IDLE with reset values and aborts the copy. No done pulse is produced.

Optional Feature:
- Macro OAM_DMA_ODD_ALIGN_EN.
- Defined: the ALIGN2 extra cycle is inserted when parity==1 in ALIGN, matching 2A03 513/514-cycle timing.
- Undefined: ALIGN2 is unreachable and may be omitted; the stall is always 513 cycles. The parity flop may be removed.

Decomposition:
- nes_pkg holds:
  - typedef enum logic [2:0] oam_dma_state_t {IDLE, ALIGN, ALIGN2, READ, WRITE, DONE};
  - constants REG_OAMDMA=16'h4014 and REG_OAMDATA=16'h2004, used as parameter defaults.
- Single module; no sub-module warranted.

Test Plan:
- Reset held 3 cycles -> oam_dma=0, cpu_rdy=1, dma_we=0, done=0. Release -> state IDLE.
- Write 8'h02 to $4014 with parity even, mem model returns low byte of address -> 256 writes to $2004 with data 00..FF, reads from $0200..$02FF, cpu_rdy low exactly 513 cycles, done pulses once.
- Same stimulus with parity odd, macro defined -> 514 stall cycles. Macro undefined -> 513.
- Second $4014 write (page 8'h05) mid-transfer -> ignored; source addresses stay in page $02; the count of writes stays 256.
- Page 8'hFF -> final read address $FFFF, idx wraps to 00, return to IDLE, no extra write.
- Reset asserted after write #100 -> next cycle oam_dma=0, cpu_rdy=1, no done. A new trigger afterwards restarts at idx 0.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and CPU register addresses.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ALIGN2 = 3'd2,
        READ   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } oam_dma_state_t;

    localparam logic [15:0] REG_OAMDMA  = 16'h4014;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine for $4014: a write of page P stalls the CPU and copies
// $PP00-$PPFF into OAMDATA, one read/write pair per byte.
// Build option: OAM_DMA_ODD_ALIGN_EN adds the extra alignment cycle when the
// DMA starts on an odd CPU cycle (513/514-cycle stall like the 2A03).
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR    = REG_OAMDMA,
    parameter logic [15:0] OAMDATA_ADDR = REG_OAMDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] dma_addr,
    output logic        dma_we,
    output logic [7:0]  dma_wdata,
    output logic        oam_dma,
    output logic        cpu_rdy,
    output logic        done
);

    oam_dma_state_t state, state_nxt;
    logic [7:0]     page;
    logic [7:0]     idx;
    logic [15:0]    addr_q;   // last address driven, held outside READ/WRITE
    logic           trig;

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic parity;

    // Free-running CPU cycle parity used to decide the extra alignment cycle.
    always_ff @(posedge clk) begin
        if (reset) parity <= 1'b0;
        else       parity <= ~parity;
    end
`endif

    assign trig = cpu_we && (cpu_addr == TRIG_ADDR);

    // Next-state decode; triggers only matter in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (trig) state_nxt = ALIGN;
`ifdef OAM_DMA_ODD_ALIGN_EN
            ALIGN:  state_nxt = parity ? ALIGN2 : READ;
`else
            ALIGN:  state_nxt = READ;
`endif
            ALIGN2: state_nxt = READ;
            READ:   state_nxt = WRITE;
            WRITE:  state_nxt = (idx == 8'hFF) ? DONE : READ;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched page, byte index and held address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            addr_q <= 16'h0000;
        end else begin
            state  <= state_nxt;
            addr_q <= dma_addr;
            if (state == IDLE && trig) begin
                page <= cpu_wdata;
                idx  <= 8'h00;
            end else if (state == WRITE) begin
                // FF wraps to 00 on the last byte; the FSM leaves via DONE.
                idx <= idx + 8'd1;
            end
        end
    end

    // Moore output decode; write data passes WRAM read data straight through.
    always_comb begin
        dma_addr  = addr_q;
        dma_we    = 1'b0;
        dma_wdata = 8'h00;
        oam_dma   = 1'b0;
        done      = 1'b0;
        case (state)
            ALIGN, ALIGN2: oam_dma = 1'b1;
            READ: begin
                oam_dma  = 1'b1;
                dma_addr = {page, idx};
            end
            WRITE: begin
                oam_dma   = 1'b1;
                dma_addr  = OAMDATA_ADDR;
                dma_we    = 1'b1;
                dma_wdata = mem_rdata;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        cpu_rdy = ~oam_dma;
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: randomized WRAM contents and CPU
// bus noise, with expected transfers computed from the DMA rules.
module tb_oam_dma_ctrl;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] OAMD = 16'h2004;
`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam bit ODD_EN = 1'b1;
`else
    localparam bit ODD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_wdata;
    logic        oam_dma;
    logic        cpu_rdy;
    logic        done;

    oam_dma_ctrl dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .mem_rdata(mem_rdata), .dma_addr(dma_addr),
        .dma_we(dma_we), .dma_wdata(dma_wdata), .oam_dma(oam_dma),
        .cpu_rdy(cpu_rdy), .done(done)
    );

    always #5 clk = ~clk;

    // WRAM model: byte = lut[low] ^ page, valid the cycle after the address.
    logic [7:0] lut [256];
    always @(posedge clk) mem_rdata <= lut[dma_addr[7:0]] ^ dma_addr[15:8];

    // CPU-cycle parity as the spec defines it: cleared by reset, toggles each clk.
    logic tb_par = 1'b0;
    always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;

    // Bus monitor: cumulative counters and logs of every write with its source.
    int          stall_cnt = 0;
    int          done_cnt  = 0;
    logic [15:0] prev_addr = 16'h0;
    logic [15:0] rd_q[$];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    always @(negedge clk) begin
        if (!reset) begin
            if (!cpu_rdy) stall_cnt++;
            if (done) done_cnt++;
            if (oam_dma && dma_we) begin
                rd_q.push_back(prev_addr);
                wa_q.push_back(dma_addr);
                wd_q.push_back(dma_wdata);
            end
        end
        prev_addr = dma_addr;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Trigger a DMA so the align cycle falls on the requested parity.
    task automatic start_dma(input logic [7:0] pg, input bit want_odd,
                             output int exp_stall, output int s0, output int w0, output int d0);
        tick();
        if ((~tb_par) !== want_odd) tick();
        exp_stall = 513 + ((want_odd && ODD_EN) ? 1 : 0);
        s0 = stall_cnt;
        w0 = wa_q.size();
        d0 = done_cnt;
        cpu_addr  = TRIG;
        cpu_we    = 1'b1;
        cpu_wdata = pg;
        tick();
        cpu_we = 1'b0;
        check("align_oam_dma", {31'd0, oam_dma}, 32'd1);
        check("align_cpu_rdy", {31'd0, cpu_rdy}, 32'd0);
        check("align_dma_we",  {31'd0, dma_we},  32'd0);
    endtask

    // Run to completion with CPU noise, then compare against the expected copy.
    task automatic finish_dma(input logic [7:0] pg, input int exp_stall, input bit poke,
                              input int s0, input int w0, input int d0);
        bit got_done = 1'b0;
        int bad_rd = 0, bad_wa = 0, bad_wd = 0;
        for (int c = 0; c < 700 && !got_done; c++) begin
            if (poke && c == 200) begin
                cpu_addr = TRIG; cpu_we = 1'b1; cpu_wdata = 8'h05;
            end else begin
                cpu_addr  = 16'($urandom_range(0, 16'h3FFF));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_wdata = 8'($urandom);
            end
            tick();
            if (done) got_done = 1'b1;
        end
        check("done_seen", {31'd0, got_done}, 32'd1);
        // A trigger during DONE must not start a new DMA.
        cpu_addr = TRIG; cpu_we = 1'b1; cpu_wdata = 8'($urandom);
        tick();
        cpu_we = 1'b0;
        check("idle_oam_dma", {31'd0, oam_dma}, 32'd0);
        check("idle_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("idle_done",    {31'd0, done},    32'd0);
        check("stall_cycles", stall_cnt - s0, exp_stall);
        check("done_pulses",  done_cnt - d0, 32'd1);
        check("write_count",  wa_q.size() - w0, 32'd256);
        if (wa_q.size() >= w0 + 256) begin
            for (int i = 0; i < 256; i++) begin
                if (rd_q[w0+i] !== {pg, 8'(i)})     bad_rd++;
                if (wa_q[w0+i] !== OAMD)            bad_wa++;
                if (wd_q[w0+i] !== (lut[i] ^ pg))   bad_wd++;
            end
            check("first_src_addr", rd_q[w0], {16'd0, pg, 8'h00});
            check("last_src_addr",  rd_q[w0+255], {16'd0, pg, 8'hFF});
            check("last_wdata",     wd_q[w0+255], {24'd0, lut[255] ^ pg});
        end
        check("src_addr_errs", bad_rd, 32'd0);
        check("dst_addr_errs", bad_wa, 32'd0);
        check("wdata_errs",    bad_wd, 32'd0);
    endtask

    initial begin
        int es, s0, w0, d0, dsave;
        for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
        reset = 1'b1; cpu_addr = 16'h0; cpu_we = 1'b0; cpu_wdata = 8'h0;
        repeat (3) tick();
        check("rst_oam_dma",   {31'd0, oam_dma}, 32'd0);
        check("rst_cpu_rdy",   {31'd0, cpu_rdy}, 32'd1);
        check("rst_dma_we",    {31'd0, dma_we},  32'd0);
        check("rst_done",      {31'd0, done},    32'd0);
        check("rst_dma_addr",  {16'd0, dma_addr}, 32'd0);
        check("rst_dma_wdata", {24'd0, dma_wdata}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_after_rst", {30'd0, oam_dma, cpu_rdy}, 32'd1);

        // Page 02, even alignment, with an ignored mid-transfer $4014 write.
        start_dma(8'h02, 1'b0, es, s0, w0, d0);
        finish_dma(8'h02, es, 1'b1, s0, w0, d0);

        // Page 02, odd alignment.
        start_dma(8'h02, 1'b1, es, s0, w0, d0);
        finish_dma(8'h02, es, 1'b0, s0, w0, d0);

        // Page FF: last read $FFFF, no wrap into page 00.
        start_dma(8'hFF, 1'($urandom_range(0, 1)), es, s0, w0, d0);
        finish_dma(8'hFF, es, 1'b0, s0, w0, d0);

        // Reset after write #100 aborts with no done pulse.
        start_dma(8'h03, 1'b0, es, s0, w0, d0);
        for (int c = 0; c < 400 && wa_q.size() < w0 + 100; c++) tick();
        check("reached_100_writes", {31'd0, wa_q.size() >= w0 + 100}, 32'd1);
        reset = 1'b1;
        tick();
        check("abort_oam_dma",  {31'd0, oam_dma}, 32'd0);
        check("abort_cpu_rdy",  {31'd0, cpu_rdy}, 32'd1);
        check("abort_done",     {31'd0, done},    32'd0);
        check("abort_dma_we",   {31'd0, dma_we},  32'd0);
        check("abort_dma_addr", {16'd0, dma_addr}, 32'd0);
        reset = 1'b0;
        dsave = done_cnt;
        repeat (5) tick();
        check("abort_no_done",  done_cnt, dsave);
        check("abort_stays_idle", {31'd0, oam_dma}, 32'd0);

        // Restart after abort begins at idx 0.
        start_dma(8'h44, 1'($urandom_range(0, 1)), es, s0, w0, d0);
        finish_dma(8'h44, es, 1'b0, s0, w0, d0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
